cart_bus_arbiter: RTL and testbench
===================================

# cart_bus_arbiter

Sequences and shares the external cartridge bus between two requesters: the CPU memory port and the OAM DMA engine. Each access runs through a fixed multi-cycle bus cycle with programmable strobe width, so slow cartridge ROM/RAM sees stable address and data around its read/write strobes. The block sits between the memory-interface requesters and the cartridge pin driver, and owns all cartridge bus timing.

## Interface
Parameters:
- STROBE_CYCLES, 3, cycles n_rd/n_wr held low per access (legal range: 1 or more)
- STARVE_LIMIT, 4, consecutive CPU grants allowed while DMA waits before DMA is forced (legal range: 1 or more)

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; level, held until cpu_done
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  16  CPU address; stable while cpu_req
- cpu_wdata  in  8  CPU write data; stable while cpu_req
- cpu_done  out  1  one-cycle pulse: CPU access complete
- cpu_rdata  out  8  last CPU read data; held until next CPU read completes
- dma_req / dma_we / dma_addr / dma_wdata / dma_done / dma_rdata  same as CPU set, for DMA
- bus_addr  out  16  cartridge address
- bus_wdata  out  8  cartridge write data
- bus_oe  out  1  1 = drive bus_wdata onto the data pins
- bus_rdata  in  8  cartridge data pins (input path)
- n_rd  out  1  active-low read strobe
- n_wr  out  1  active-low write strobe
- n_cs  out  1  active-low external-RAM select
- busy  out  1  1 whenever state is not IDLE

## Operation
- States: IDLE, SETUP, STROBE, HOLD. All outputs are registered.
- IDLE: arbitrate on the sampled requests.
  - Neither request high: stay in IDLE.
  - Only one request high: grant that requester.
  - Both high: grant CPU unless starve_cnt == STARVE_LIMIT, in which case grant DMA.
  - On a grant, latch the owner, we, addr and wdata, then go to SETUP.
- SETUP (1 cycle):
  - bus_addr = latched addr.
  - bus_oe = we; bus_wdata = latched wdata.
  - n_cs = 0 iff 0xA000 <= addr <= 0xBFFF.
  - Strobes remain high. Next state: STROBE.
- STROBE (STROBE_CYCLES cycles):
  - n_rd = ~(!we); n_wr = ~we.
  - Address, data and n_cs unchanged.
  - Counter width is clog2(STROBE_CYCLES+1). The counter counts down.
  - On the last STROBE edge, a read captures bus_rdata into the owner's rdata register. Next state: HOLD.
- HOLD (1 cycle):
  - Strobes high; address, data, bus_oe and n_cs still held.
  - The owner's done = 1. Next state: IDLE.
- Leaving HOLD (IDLE entry): bus_oe = 0, n_cs = 1. bus_addr and bus_wdata keep their last values.
- Starvation counter starve_cnt, width clog2(STARVE_LIMIT+1):
  - On a CPU grant while dma_req = 1: increment, saturating at STARVE_LIMIT.
  - On a DMA grant, or when dma_req = 0 in IDLE: clear to 0.
- Requester rule: drop req on the edge ending the done cycle, or keep it high to request another access. The arbiter samples req only in IDLE.
- A write never modifies rdata.

## Timing
- Reset values:
  - state IDLE
  - bus_addr 0, bus_wdata 0, bus_oe 0
  - n_rd 1, n_wr 1, n_cs 1
  - cpu_done 0, dma_done 0
  - cpu_rdata 0, dma_rdata 0
  - busy 0, starve_cnt 0
- Reset asserted mid-access:
  - All outputs go to their reset values immediately (asynchronously).
  - No done pulse is issued. The access is lost; the requester re-issues it after reset.
- Latency, with the grant taken at edge k:
  - SETUP during cycle k+1.
  - Strobes low during cycles k+2 .. k+1+STROBE_CYCLES.
  - done high during cycle k+2+STROBE_CYCLES.
  - rdata valid from the start of the done cycle.
- Throughput: one access per STROBE_CYCLES+3 cycles. IDLE always lasts at least one cycle between accesses.
- A request arriving during an access is held off until IDLE. No preemption occurs.

## Test plan
- CPU read 0x0150 with STROBE_CYCLES=3 and bus_rdata=0x3C:
  - n_rd low for exactly 3 cycles; n_cs stays 1.
  - cpu_done pulses once, 5 cycles after the grant edge.
  - cpu_rdata = 0x3C and holds after bus_rdata changes.
- CPU write 0x5A to 0xA123:
  - n_cs = 0 and bus_oe = 1 from SETUP through HOLD.
  - n_wr low for 3 cycles; n_rd stays 1.
  - cpu_rdata unchanged.
- cpu_req and dma_req rise in the same cycle: CPU is served first, DMA is served immediately after, and each done pulses once.
- cpu_req held high continuously with dma_req high and STARVE_LIMIT=4: grant sequence is CPU, CPU, CPU, CPU, DMA, CPU…
- n_rst driven low during the 2nd STROBE cycle:
  - n_rd returns to 1 and bus_oe to 0 with no clock edge.
  - No done pulse; state is IDLE after release.
- Boundary addresses 0x9FFF, 0xA000, 0xBFFF, 0xC000 give n_cs = 1, 0, 0, 1 respectively.

Source files
------------

// File: rtl/cart_bus_arbiter.sv
// cart_bus_arbiter
// Shares the cartridge bus between the CPU memory port and the OAM DMA
// engine. Every access is a fixed SETUP / STROBE / HOLD bus cycle so slow
// cartridge ROM/RAM sees stable address and data around its strobes.
// All outputs come straight from flops.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | bus released, arbitrate on sampled cpu_req_i / dma_req_i
// S_SETUP  | address, data, n_cs and bus_oe driven, strobes still high
// S_STROBE | n_rd or n_wr low for STROBE_CYCLES cycles (down-counter)
// S_HOLD   | strobes high, bus still held, owner's done pulses
module cart_bus_arbiter #(
    parameter int STROBE_CYCLES = 3,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic        cpu_done_o,
    output logic [7:0]  cpu_rdata_o,
    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [15:0] dma_addr_i,
    input  logic [7:0]  dma_wdata_i,
    output logic        dma_done_o,
    output logic [7:0]  dma_rdata_o,
    output logic [15:0] bus_addr_o,
    output logic [7:0]  bus_wdata_o,
    output logic        bus_oe_o,
    input  logic [7:0]  bus_rdata_i,
    output logic        n_rd_o,
    output logic        n_wr_o,
    output logic        n_cs_o,
    output logic        busy_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam int CW = $clog2(STROBE_CYCLES + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE  = SW'(1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          owner_q, owner_d;     // 0 = CPU, 1 = DMA
    logic          we_q, we_d;
    logic [15:0]   bus_addr_q, bus_addr_d;
    logic [7:0]    bus_wdata_q, bus_wdata_d;
    logic          bus_oe_q, bus_oe_d;
    logic          n_rd_q, n_rd_d;
    logic          n_wr_q, n_wr_d;
    logic          n_cs_q, n_cs_d;
    logic          cpu_done_q, cpu_done_d;
    logic          dma_done_q, dma_done_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic [7:0]    dma_rdata_q, dma_rdata_d;
    logic          busy_q, busy_d;

    logic          grant_cpu, grant_dma;
    logic          sel_we;
    logic [15:0]   sel_addr;
    logic [7:0]    sel_wdata;
    logic          sel_in_ram;

    // Arbitration: CPU wins ties until DMA has waited STARVE_LIMIT grants.
    always_comb begin
        grant_cpu  = cpu_req_i && (!dma_req_i || (starve_q != STARVE_MAX));
        grant_dma  = dma_req_i && !grant_cpu;
        sel_we     = grant_dma ? dma_we_i    : cpu_we_i;
        sel_addr   = grant_dma ? dma_addr_i  : cpu_addr_i;
        sel_wdata  = grant_dma ? dma_wdata_i : cpu_wdata_i;
        sel_in_ram = (sel_addr >= 16'hA000) && (sel_addr <= 16'hBFFF);
    end

    // Bus-cycle sequencing and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        we_d        = we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_oe_d    = bus_oe_q;
        n_rd_d      = n_rd_q;
        n_wr_d      = n_wr_q;
        n_cs_d      = n_cs_q;
        cpu_done_d  = 1'b0;
        dma_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (!dma_req_i) begin
                    starve_d = '0;
                end
                if (grant_cpu || grant_dma) begin
                    state_d     = S_SETUP;
                    owner_d     = grant_dma;
                    we_d        = sel_we;
                    bus_addr_d  = sel_addr;
                    bus_wdata_d = sel_wdata;
                    bus_oe_d    = sel_we;
                    n_cs_d      = !sel_in_ram;
                    if (grant_dma) begin
                        starve_d = '0;
                    end else if (dma_req_i && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + STARVE_ONE;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = STROBE_LOAD;
                n_rd_d  = we_q;
                n_wr_d  = !we_q;
            end
            S_STROBE: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_HOLD;
                    n_rd_d  = 1'b1;
                    n_wr_d  = 1'b1;
                    if (owner_q) begin
                        dma_done_d = 1'b1;
                    end else begin
                        cpu_done_d = 1'b1;
                    end
                    // Read data is captured on the edge that releases n_rd.
                    if (!we_q) begin
                        if (owner_q) begin
                            dma_rdata_d = bus_rdata_i;
                        end else begin
                            cpu_rdata_d = bus_rdata_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_HOLD: begin
                state_d  = S_IDLE;
                bus_oe_d = 1'b0;
                n_cs_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_oe_q    <= 1'b0;
            n_rd_q      <= 1'b1;
            n_wr_q      <= 1'b1;
            n_cs_q      <= 1'b1;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_oe_q    <= bus_oe_d;
            n_rd_q      <= n_rd_d;
            n_wr_q      <= n_wr_d;
            n_cs_q      <= n_cs_d;
            cpu_done_q  <= cpu_done_d;
            dma_done_q  <= dma_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_oe_o    = bus_oe_q;
    assign n_rd_o      = n_rd_q;
    assign n_wr_o      = n_wr_q;
    assign n_cs_o      = n_cs_q;
    assign cpu_done_o  = cpu_done_q;
    assign dma_done_o  = dma_done_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dma_rdata_o = dma_rdata_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Testbench for cart_bus_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a timeline model of the bus.
module tb_cart_bus_arbiter;

    localparam int S   = 3;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cpu_req, cpu_we, cpu_done;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_done;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata, bus_rdata;
    logic        bus_oe, n_rd, n_wr, n_cs, busy;

    always #5 clk = ~clk;

    cart_bus_arbiter #(.STROBE_CYCLES(S), .STARVE_LIMIT(LIM)) dut (
        .clk_i(clk), .n_rst_i(n_rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_done_o(cpu_done), .cpu_rdata_o(cpu_rdata),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
        .dma_wdata_i(dma_wdata), .dma_done_o(dma_done), .dma_rdata_o(dma_rdata),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_oe_o(bus_oe),
        .bus_rdata_i(bus_rdata), .n_rd_o(n_rd), .n_wr_o(n_wr), .n_cs_o(n_cs),
        .busy_o(busy)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    typedef struct {
        int   owner;
        int   edge_no;
        logic ncs;
    } done_t;

    txn_t  cpu_q[$];
    txn_t  dma_q[$];
    done_t done_log[$];

    // Reference model: access timeline anchored on the grant edge g.
    int          e, g, next_arb, starve;
    int          m_owner;
    logic        m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  exp_rd[2];
    logic [7:0]  cap_val;
    bit          rand_pushes, fixed_rd_en;
    logic [7:0]  fixed_rd;
    int          rd_low, wr_low;
    int          n_checks = 0, n_pass = 0, n_fail = 0;

    function automatic txn_t mk(input logic we, input logic [15:0] addr, input logic [7:0] wd);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wd;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h9FF0, 16'hC010))
                                              : 16'($urandom);
        t.wdata = 8'($urandom);
        return t;
    endfunction

    function automatic logic [63:0] expect_vec();
        logic act, strb, hold, ram;
        act  = (e >= g) && (e <= g + S + 1);
        strb = (e >= g + 1) && (e <= g + S);
        hold = (e == g + S + 1);
        ram  = (m_addr >= 16'hA000) && (m_addr <= 16'hBFFF);
        return {17'd0, act, !(strb && !m_we), !(strb && m_we), !(act && ram),
                act && m_we, hold && (m_owner == 0), hold && (m_owner == 1),
                m_addr, m_wdata, exp_rd[0], exp_rd[1]};
    endfunction

    function automatic logic [63:0] dut_vec();
        return {17'd0, busy, n_rd, n_wr, n_cs, bus_oe, cpu_done, dma_done,
                bus_addr, bus_wdata, cpu_rdata, dma_rdata};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        g = -1000; next_arb = e + 1; starve = 0;
        m_owner = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        exp_rd[0] = '0; exp_rd[1] = '0; cap_val = '0;
    endtask

    // One cycle, entered and left at a falling edge: observe, check,
    // update requesters, drive inputs, predict the next edge's grant.
    task automatic tick();
        txn_t t;
        if (cpu_done) done_log.push_back('{0, e, n_cs});
        if (dma_done) done_log.push_back('{1, e, n_cs});
        if (!n_rd) rd_low++;
        if (!n_wr) wr_low++;
        if (e == g + S + 1 && !m_we) exp_rd[m_owner] = cap_val;
        chk("cycle", dut_vec(), expect_vec());
        if (e == g + S + 1) begin
            if (m_owner == 0) void'(cpu_q.pop_front());
            else              void'(dma_q.pop_front());
        end
        if (rand_pushes) begin
            if (cpu_q.size() < 3 && $urandom_range(0, 5) == 0) cpu_q.push_back(rand_txn());
            if (dma_q.size() < 3 && $urandom_range(0, 7) == 0) dma_q.push_back(rand_txn());
        end
        cpu_req = (cpu_q.size() > 0);
        if (cpu_req) {cpu_we, cpu_addr, cpu_wdata} = cpu_q[0];
        dma_req = (dma_q.size() > 0);
        if (dma_req) {dma_we, dma_addr, dma_wdata} = dma_q[0];
        bus_rdata = fixed_rd_en ? fixed_rd : 8'($urandom);
        if (e == g + S) cap_val = bus_rdata;
        if (e + 1 >= next_arb) begin
            if (!dma_req) starve = 0;
            if (cpu_req || dma_req) begin
                if (cpu_req && !(dma_req && starve == LIM)) begin
                    m_owner = 0; t = cpu_q[0];
                    if (dma_req && starve < LIM) starve++;
                end else begin
                    m_owner = 1; t = dma_q[0];
                    starve = 0;
                end
                m_we = t.we; m_addr = t.addr; m_wdata = t.wdata;
                g = e + 1;
                next_arb = g + S + 3;
            end
        end
        @(posedge clk);
        e++;
        @(negedge clk);
    endtask

    task automatic run_until_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while ((cpu_q.size() > 0 || dma_q.size() > 0 || e <= g + S + 1) && n < max_cycles) begin
            tick();
            n++;
        end
        chk({tag, "_finished"}, (n < max_cycles), 1);
    endtask

    int         e0, n;
    int         exp_ord[8] = '{0, 0, 0, 0, 1, 0, 0, 1};
    logic [15:0] baddr[4]  = '{16'h9FFF, 16'hA000, 16'hBFFF, 16'hC000};
    logic        bncs[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        n_rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        bus_rdata = '0; rand_pushes = 0; fixed_rd_en = 0; fixed_rd = '0;
        rd_low = 0; wr_low = 0; e = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_state", dut_vec(), expect_vec());
        n_rst = 1'b1;
        repeat (2) tick();

        // CPU read of 0x0150, cartridge returns 0x3C
        fixed_rd_en = 1; fixed_rd = 8'h3C; rd_low = 0; wr_low = 0;
        done_log.delete(); e0 = e;
        cpu_q.push_back(mk(1'b0, 16'h0150, 8'h00));
        run_until_idle("rd", 50);
        chk("rd_nrd_low_cycles", rd_low, S);
        chk("rd_nwr_low_cycles", wr_low, 0);
        chk("rd_done_count", done_log.size(), 1);
        if (done_log.size() == 1) begin
            chk("rd_done_latency", done_log[0].edge_no - (e0 + 1), S + 1);
            chk("rd_ncs", done_log[0].ncs, 1);
        end
        fixed_rd_en = 0;
        repeat (3) tick();
        chk("rd_data_held", cpu_rdata, 8'h3C);

        // CPU write 0x5A to 0xA123
        rd_low = 0; wr_low = 0; done_log.delete();
        cpu_q.push_back(mk(1'b1, 16'hA123, 8'h5A));
        run_until_idle("wr", 50);
        chk("wr_nwr_low_cycles", wr_low, S);
        chk("wr_nrd_low_cycles", rd_low, 0);
        chk("wr_done_count", done_log.size(), 1);
        if (done_log.size() == 1) chk("wr_ncs_in_hold", done_log[0].ncs, 0);
        chk("wr_rdata_unchanged", cpu_rdata, 8'h3C);

        // Both requests rise together
        done_log.delete();
        cpu_q.push_back(mk(1'b0, 16'h1234, 8'h00));
        dma_q.push_back(mk(1'b0, 16'hB000, 8'h00));
        run_until_idle("tie", 60);
        chk("tie_done_count", done_log.size(), 2);
        if (done_log.size() == 2) begin
            chk("tie_first_owner", done_log[0].owner, 0);
            chk("tie_second_owner", done_log[1].owner, 1);
            chk("tie_back_to_back", done_log[1].edge_no - done_log[0].edge_no, S + 3);
        end

        // Starvation: CPU streams while DMA waits
        done_log.delete();
        repeat (6) cpu_q.push_back(mk(1'b0, 16'h2000, 8'h00));
        repeat (2) dma_q.push_back(mk(1'b1, 16'h8000, 8'hA5));
        run_until_idle("starve", 150);
        chk("starve_done_count", done_log.size(), 8);
        if (done_log.size() == 8) begin
            for (int i = 0; i < 8; i++) chk($sformatf("starve_order_%0d", i), done_log[i].owner, exp_ord[i]);
        end

        // External-RAM window boundaries
        done_log.delete();
        for (int i = 0; i < 4; i++) cpu_q.push_back(mk(1'b0, baddr[i], 8'h00));
        run_until_idle("ncs", 100);
        chk("ncs_done_count", done_log.size(), 4);
        if (done_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("ncs_%04h", baddr[i]), done_log[i].ncs, bncs[i]);
        end

        // Random traffic from both requesters
        rand_pushes = 1;
        repeat (400) tick();
        rand_pushes = 0;
        run_until_idle("random", 200);

        // Reset asserted in the 2nd strobe cycle of a read
        cpu_q.push_back(mk(1'b0, 16'hA010, 8'h00));
        n = 0;
        while (e != g + 2 && n < 20) begin
            tick();
            n++;
        end
        chk("rst_reached_strobe", (n < 20), 1);
        chk("rst_pre_nrd", n_rd, 0);
        #2 n_rst = 1'b0;
        #1;
        chk("rst_async_ctrl", {n_rd, n_wr, bus_oe, n_cs, busy, cpu_done}, 6'b110100);
        chk("rst_async_addr", bus_addr, 16'h0000);
        cpu_q.delete(); dma_q.delete();
        cpu_req = 0; dma_req = 0;
        @(posedge clk);
        e++;
        @(negedge clk);
        n_rst = 1'b1;
        model_reset();
        done_log.delete();
        repeat (5) tick();
        chk("rst_no_done", done_log.size(), 0);

        // Access after reset
        dma_q.push_back(mk(1'b0, 16'h0042, 8'h00));
        run_until_idle("post_rst", 50);
        chk("post_rst_done_count", done_log.size(), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
